// File: rtl/snare_envelope_pkg.sv
// Shared types and default widths for the snare amplitude envelope.
package snare_envelope_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ATTACK = 2'd1,
        DECAY  = 2'd2
    } env_state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ENV_W       = 16;
    localparam int DEF_ATTACK_STEP = 4096;

endpackage

// File: rtl/snare_envelope_if.sv
// Sample/control bundle between the snare mixers, the envelope and the out mixer.
// The velocity signal exists only when SNARE_VELOCITY_EN is defined.
interface snare_envelope_if
    import snare_envelope_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ENV_W  = DEF_ENV_W
) ();

    logic                     sample_tick;
    logic                     trigger;
    logic [3:0]               decay_rate;
    logic signed [DATA_W-1:0] sample_in;
    logic signed [DATA_W-1:0] sample_out;
    logic                     sample_valid;
    logic [ENV_W-1:0]         env_level;
    logic                     active;
`ifdef SNARE_VELOCITY_EN
    logic [7:0]               velocity;
`endif

    modport master (
`ifdef SNARE_VELOCITY_EN
        output velocity,
`endif
        output sample_tick, trigger, decay_rate, sample_in,
        input  sample_out, sample_valid, env_level, active
    );

    modport slave (
`ifdef SNARE_VELOCITY_EN
        input  velocity,
`endif
        input  sample_tick, trigger, decay_rate, sample_in,
        output sample_out, sample_valid, env_level, active
    );

endinterface

// File: rtl/snare_envelope_env_mult.sv
// Registered signed sample times unsigned level, scaled back by 2^ENV_W (arithmetic shift),
// truncated to DATA_W. Output holds between enables.
module env_mult #(
    parameter int DATA_W = 16,
    parameter int ENV_W  = 16
) (
    input  logic                     main_clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic [ENV_W-1:0]         level_i,
    output logic signed [DATA_W-1:0] sample_o,
    output logic                     valid_o
);

    logic signed [DATA_W+ENV_W:0] product;
    logic signed [DATA_W-1:0]     sample_d;
    logic signed [DATA_W-1:0]     sample_q;
    logic                         valid_q;
    logic                         unused_bits;

    // Zero-extending the level keeps it non-negative in the signed multiply.
    assign product     = sample_i * $signed({1'b0, level_i});
    assign sample_d    = product[ENV_W +: DATA_W];
    assign unused_bits = ^{product[ENV_W-1:0], product[DATA_W+ENV_W]};

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= en_i;
            if (en_i) begin
                sample_q <= sample_d;
            end
        end
    end

    assign sample_o = sample_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/snare_envelope.sv
// Snare amplitude envelope: linear attack to peak, multiplicative decay, sample scaling.
// Optional feature macro: SNARE_VELOCITY_EN (velocity-scaled peak, velocity 0 mutes).
module snare_envelope
    import snare_envelope_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ENV_W       = DEF_ENV_W,
    parameter int ATTACK_STEP = DEF_ATTACK_STEP
) (
    input  logic           main_clk,
    input  logic           reset,
    snare_envelope_if.slave bus
);

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] level_q, level_d;
    logic             active_q;
    logic [ENV_W-1:0] peak;
    logic [ENV_W:0]   attack_sum;
    logic [ENV_W:0]   decay_sub;

`ifdef SNARE_VELOCITY_EN
    logic [7:0] vel_q, vel_d;

    assign vel_d = bus.trigger ? bus.velocity : vel_q;
    assign peak  = {vel_q, vel_q[7 -: ENV_W-8]};
`else
    assign peak  = '1;
`endif

    // One extra bit on both paths so saturation and underflow are detected, never wrapped.
    assign attack_sum = {1'b0, level_q} + (ENV_W+1)'(ATTACK_STEP);
    assign decay_sub  = {1'b0, (level_q >> bus.decay_rate)} + (ENV_W+1)'(1);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (bus.trigger) begin
            // Retrigger continues from the current level; the tick step is skipped.
            state_d = ATTACK;
`ifdef SNARE_VELOCITY_EN
            if (bus.velocity == 8'd0) begin
                state_d = IDLE;
                level_d = '0;
            end
`endif
        end else if (bus.sample_tick) begin
            case (state_q)
                ATTACK: begin
                    if (attack_sum >= {1'b0, peak}) begin
                        level_d = peak;
                        state_d = DECAY;
                    end else begin
                        level_d = attack_sum[ENV_W-1:0];
                    end
                end
                DECAY: begin
                    if (decay_sub >= {1'b0, level_q}) begin
                        level_d = '0;
                        state_d = IDLE;
                    end else begin
                        level_d = level_q - decay_sub[ENV_W-1:0];
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            level_q  <= '0;
            active_q <= 1'b0;
`ifdef SNARE_VELOCITY_EN
            vel_q    <= 8'hFF;
`endif
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            active_q <= (state_q != IDLE);
`ifdef SNARE_VELOCITY_EN
            vel_q    <= vel_d;
`endif
        end
    end

    assign bus.env_level = level_q;
    assign bus.active    = active_q;

    // The multiplier sees the level before this tick's update.
    env_mult #(
        .DATA_W (DATA_W),
        .ENV_W  (ENV_W)
    ) u_env_mult (
        .main_clk (main_clk),
        .reset    (reset),
        .en_i     (bus.sample_tick),
        .sample_i (bus.sample_in),
        .level_i  (level_q),
        .sample_o (bus.sample_out),
        .valid_o  (bus.sample_valid)
    );

endmodule
